// File: rtl/lsu_misalign.sv
// rtl/lsu_misalign.sv - load/store alignment unit: aligned pass-through, misaligned split into byte accesses
module lsu_misalign #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  mem_wr_en,
  output logic [2:0]            mem_funct3,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  stall,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [CNT_WIDTH-1:0]  misalign_cnt
);

  typedef enum logic [1:0] {IDLE, SPLIT, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] buf_q;
  logic [2:0]            funct3_q;
  logic                  we_q;
  logic [1:0]            k;
  logic                  misaligned;
  logic [1:0]            last_k;
  logic [4:0]            bit_ofs;

  // funct3 110 shares the word size code but is not a legal RV32I access, so it never splits
  assign misaligned = req_valid &&
                      (((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3 != 3'b110) && (req_funct3[1:0] == 2'b10) &&
                        (req_addr[1:0] != 2'b00)));

  assign last_k  = (funct3_q[1:0] == 2'b01) ? 2'd1 : 2'd3;
  assign bit_ofs = {k, 3'b000};

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      base_q       <= '0;
      wdata_q      <= '0;
      buf_q        <= '0;
      funct3_q     <= '0;
      we_q         <= 1'b0;
      k            <= '0;
      misalign_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (misaligned) begin
            base_q   <= req_addr;
            wdata_q  <= req_wdata;
            funct3_q <= req_funct3;
            we_q     <= req_we;
            k        <= '0;
            buf_q    <= '0;
            state    <= SPLIT;
          end
        end
        SPLIT: begin
          if (!we_q) buf_q[bit_ofs +: 8] <= mem_rd_data[7:0];
          if (k == last_k) state <= DONE;
          else             k     <= k + 2'd1;
        end
        DONE: begin
          if (misalign_cnt != '1) misalign_cnt <= misalign_cnt + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_wr_en   = req_valid & req_we;
    mem_funct3  = req_funct3;
    mem_addr    = req_addr;
    mem_wr_data = req_wdata;
    resp_valid  = req_valid & ~req_we;
    resp_rdata  = mem_rd_data;
    stall       = 1'b0;
    if (reset) begin
      mem_wr_en  = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = '0;
    end else begin
      case (state)
        IDLE: begin
          if (misaligned) begin
            stall      = 1'b1;
            mem_wr_en  = 1'b0;
            resp_valid = 1'b0;
          end
        end
        SPLIT: begin
          stall       = 1'b1;
          mem_addr    = base_q + {{(ADDR_WIDTH-2){1'b0}}, k};
          mem_funct3  = we_q ? 3'b000 : 3'b100;
          mem_wr_data = {{(DATA_WIDTH-8){1'b0}}, wdata_q[bit_ofs +: 8]};
          mem_wr_en   = we_q;
          resp_valid  = 1'b0;
        end
        DONE: begin
          mem_wr_en  = 1'b0;
          resp_valid = ~we_q;
          case (funct3_q)
            3'b001:  resp_rdata = {{(DATA_WIDTH-16){buf_q[15]}}, buf_q[15:0]};
            3'b101:  resp_rdata = {{(DATA_WIDTH-16){1'b0}}, buf_q[15:0]};
            default: resp_rdata = buf_q;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_misalign.sv
// tb/tb_lsu_misalign.sv - scoreboard bench for lsu_misalign with a byte-addressed memory model
module tb_lsu_misalign;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_wr_en;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [15:0] misalign_cnt;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem [0:255];
  logic        mem_clr;
  logic [31:0] rsp_q[$];
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [31:0] wf_q[$];
  logic [31:0] tr [0:7];
  int          trn;

  lsu_misalign #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_wr_en(mem_wr_en), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .stall(stall),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .misalign_cnt(misalign_cnt)
  );

  always #5 clk = ~clk;

  // only the low address byte is decoded; the test addresses never alias
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (mem_wr_en) begin
      case (mem_funct3[1:0])
        2'b00: mem[mem_addr[7:0]] <= mem_wr_data[7:0];
        2'b01: for (int i = 0; i < 2; i++) mem[mem_addr[7:0] + 8'(i)] <= mem_wr_data[8*i +: 8];
        default: for (int i = 0; i < 4; i++) mem[mem_addr[7:0] + 8'(i)] <= mem_wr_data[8*i +: 8];
      endcase
    end
  end

  always_comb begin
    logic [7:0] a;
    a = mem_addr[7:0];
    case (mem_funct3)
      3'b000:  mem_rd_data = {{24{mem[a][7]}}, mem[a]};
      3'b100:  mem_rd_data = {24'h0, mem[a]};
      3'b001:  mem_rd_data = {{16{mem[a+8'd1][7]}}, mem[a+8'd1], mem[a]};
      3'b101:  mem_rd_data = {16'h0, mem[a+8'd1], mem[a]};
      default: mem_rd_data = {mem[a+8'd3], mem[a+8'd2], mem[a+8'd1], mem[a]};
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    wa_q.push_back(a);
    wd_q.push_back(d);
    wf_q.push_back({29'h0, f3});
  endtask

  // response monitor
  always @(negedge clk) begin
    if (resp_valid) begin
      if (rsp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rsp_unexpected actual=%h expected=none", resp_rdata);
      end else begin
        chk("resp_rdata", resp_rdata, rsp_q.pop_front());
      end
    end
  end

  // write monitor
  always @(negedge clk) begin
    if (mem_wr_en) begin
      if (wa_q.size() == 0) begin
        total++; bad++;
        $display("FAIL wr_unexpected actual=%h@%h expected=none", mem_wr_data, mem_addr);
      end else begin
        chk("wr_addr", mem_addr, wa_q.pop_front());
        chk("wr_data", mem_wr_data, wd_q.pop_front());
        chk("wr_funct3", {29'h0, mem_funct3}, wf_q.pop_front());
      end
    end
  end

  // called just after a posedge; returns just after the posedge that ends the access
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input int exp_stall, input string nm);
    int st = 0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
    trn = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!stall) break;
      if (trn < 8) tr[trn] = mem_addr;
      trn++;
      st++;
    end
    chk({nm, "_stall_cycles"}, st, exp_stall);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mem_clr = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h12345678;
    @(negedge clk);
    chk("rst_stall", {31'h0, stall}, 0);
    chk("rst_wr_en", {31'h0, mem_wr_en}, 0);
    chk("rst_resp_valid", {31'h0, resp_valid}, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_cnt", {16'h0, misalign_cnt}, 0);
    @(posedge clk); #1;
    reset = 1'b0; mem_clr = 1'b0; req_valid = 1'b0;

    // aligned store then load
    exp_wr(32'h10, 32'hDEADBEEF, 3'b010);
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, "sw_al");
    rsp_q.push_back(32'hDEADBEEF);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, "lw_al");

    // misaligned store split into bytes
    exp_wr(32'h5, 32'h44, 3'b000);
    exp_wr(32'h6, 32'h33, 3'b000);
    exp_wr(32'h7, 32'h22, 3'b000);
    exp_wr(32'h8, 32'h11, 3'b000);
    do_req(1'b1, 3'b010, 32'h5, 32'h11223344, 5, "sw_mis");
    rsp_q.push_back(32'h22334400);
    do_req(1'b0, 3'b010, 32'h4, 32'h0, 0, "lw4");
    rsp_q.push_back(32'h00000011);
    do_req(1'b0, 3'b010, 32'h8, 32'h0, 0, "lw8");
    chk("cnt_after_sw", {16'h0, misalign_cnt}, 1);

    // misaligned halfword loads
    exp_wr(32'h3, 32'h34, 3'b000);
    do_req(1'b1, 3'b000, 32'h3, 32'h34, 0, "sb3");
    exp_wr(32'h4, 32'h92, 3'b000);
    do_req(1'b1, 3'b000, 32'h4, 32'h92, 0, "sb4");
    rsp_q.push_back(32'hFFFF9234);
    do_req(1'b0, 3'b001, 32'h3, 32'h0, 3, "lh_mis");
    rsp_q.push_back(32'h00009234);
    do_req(1'b0, 3'b101, 32'h3, 32'h0, 3, "lhu_mis");
    chk("cnt_after_lh", {16'h0, misalign_cnt}, 3);

    // word load across the top of the address space
    exp_wr(32'hFFFFFFFE, 32'hAA, 3'b000);
    do_req(1'b1, 3'b000, 32'hFFFFFFFE, 32'hAA, 0, "sbfe");
    exp_wr(32'hFFFFFFFF, 32'hBB, 3'b000);
    do_req(1'b1, 3'b000, 32'hFFFFFFFF, 32'hBB, 0, "sbff");
    exp_wr(32'h0, 32'hCC, 3'b000);
    do_req(1'b1, 3'b000, 32'h0, 32'hCC, 0, "sb0");
    exp_wr(32'h1, 32'hDD, 3'b000);
    do_req(1'b1, 3'b000, 32'h1, 32'hDD, 0, "sb1");
    rsp_q.push_back(32'hDDCCBBAA);
    do_req(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 5, "lw_wrap");
    chk("wrap_addr0", tr[1], 32'hFFFFFFFE);
    chk("wrap_addr1", tr[2], 32'hFFFFFFFF);
    chk("wrap_addr2", tr[3], 32'h00000000);
    chk("wrap_addr3", tr[4], 32'h00000001);
    chk("cnt_after_wrap", {16'h0, misalign_cnt}, 4);

    // reset during SPLIT at k=2
    exp_wr(32'h1, 32'h88, 3'b000);
    exp_wr(32'h2, 32'h77, 3'b000);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h1; req_wdata = 32'h55667788;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("midrst_stall", {31'h0, stall}, 0);
    chk("midrst_wr_en", {31'h0, mem_wr_en}, 0);
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("abort_stall", {31'h0, stall}, 0);
    chk("abort_cnt", {16'h0, misalign_cnt}, 0);
    @(posedge clk); #1;
    rsp_q.push_back(32'h347788CC);
    do_req(1'b0, 3'b010, 32'h0, 32'h0, 0, "lw0_after_abort");

    // aligned lb straight after a misaligned DONE cycle
    exp_wr(32'h6, 32'hF0, 3'b000);
    exp_wr(32'h7, 32'hF0, 3'b000);
    exp_wr(32'h8, 32'h00, 3'b000);
    exp_wr(32'h9, 32'h00, 3'b000);
    do_req(1'b1, 3'b010, 32'h6, 32'h0000F0F0, 5, "sw6_mis");
    rsp_q.push_back(32'hFFFFFFF0);
    do_req(1'b0, 3'b000, 32'h7, 32'h0, 0, "lb7");
    chk("cnt_final", {16'h0, misalign_cnt}, 1);

    repeat (3) @(posedge clk);
    chk("rsp_q_drained", rsp_q.size(), 0);
    chk("wr_q_drained", wa_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
